// File: rtl/quasi_bus_pkg.sv
// Shared definitions for quasiSoC bus adapters.
//   bus_state_e      : responder FSM states shared by the bridge family
//   WSTRB_WORD       : full-word write strobe
//   ERR_WORD_DEFAULT : read data returned when a native access is abandoned
//   byte_swap32      : reverses byte lanes between quasiSoC and picorv32 order
package quasi_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } bus_state_e;

   localparam logic [3:0]  WSTRB_WORD       = 4'hF;
   localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Cycle watchdog for bus adapters waiting on a slave.
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : restart count from zero (has priority over en)
//   en          : count this cycle (saturates at all-ones)
//   expire      : combinational; high while en and the count sits on the last allowed cycle
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] LastCnt =
      (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {CntW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt_q == LastCnt);

endmodule

// File: rtl/quasi2pico_bridge.sv
// quasiSoC responder to picorv32-native initiator bridge.
//   clk, resetn         : clock, asynchronous active-low reset
//   a, d, we, rd        : quasiSoC request; we/rd held by master until ready
//   spo, ready, err     : last completed read data, completion pulse, timeout flag
//   mem_valid/instr/addr/wdata/wstrb : native request (word accesses only)
//   mem_ready, mem_rdata: native completion and read data
// A watchdog aborts a BUSY access after TIMEOUT_CYCLES so a dead slave cannot
// hang the master; an aborted read returns ERR_WORD.
module quasi2pico_bridge
   import quasi_bus_pkg::*;
#(
   parameter bit              BYTE_SWAP      = 1'b1,
   parameter int unsigned     TIMEOUT_CYCLES = 1024,
   parameter logic [31:0]     ERR_WORD       = ERR_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] a,
   input  logic [31:0] d,
   input  logic        we,
   input  logic        rd,
   output logic [31:0] spo,
   output logic        ready,
   output logic        err,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   bus_state_e  state_q, state_d;
   logic [31:0] spo_q, spo_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;

   logic wd_clr, wd_en, wd_expire;

   // Only word accesses exist; the byte offset is intentionally dropped.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^a[1:0];

   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   assign wd_en = (state_q == BUSY);

   always_comb begin
      state_d     = state_q;
      spo_d       = spo_q;
      ready_d     = 1'b0;
      err_d       = 1'b0;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      wd_clr      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rd || we) begin
               mem_addr_d  = {a[31:2], 2'b00};
               mem_wdata_d = BYTE_SWAP ? byte_swap32(d) : d;
               // we wins when both are raised
               mem_wstrb_d = we ? WSTRB_WORD : 4'h0;
               mem_valid_d = 1'b1;
               wd_clr      = 1'b1;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            // A completion on the expiry cycle takes priority over the abort.
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               mem_wstrb_d = 4'h0;
               if (mem_wstrb_q == 4'h0) begin
                  spo_d = BYTE_SWAP ? byte_swap32(mem_rdata) : mem_rdata;
               end
               ready_d = 1'b1;
               state_d = RESP;
            end else if (wd_expire) begin
               mem_valid_d = 1'b0;
               if (mem_wstrb_q == 4'h0) begin
                  spo_d = ERR_WORD;
               end
               ready_d = 1'b1;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            // Wait for the master to drop its held request before rearming.
            if (!rd && !we) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         spo_q       <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         spo_q       <= spo_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
      end
   end

   assign spo       = spo_q;
   assign ready     = ready_q;
   assign err       = err_q;
   assign mem_valid = mem_valid_q;
   assign mem_instr = 1'b0;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_quasi2pico_bridge.sv
// Self-checking bench for quasi2pico_bridge (BYTE_SWAP=1, TIMEOUT_CYCLES=16).
module tb_quasi2pico_bridge;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] a, d;
   logic        we, rd;
   logic [31:0] spo;
   logic        ready, err;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   quasi2pico_bridge #(
      .BYTE_SWAP      (1'b1),
      .TIMEOUT_CYCLES (TO),
      .ERR_WORD       (32'hDEADBEEF)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .a         (a),
      .d         (d),
      .we        (we),
      .rd        (rd),
      .spo       (spo),
      .ready     (ready),
      .err       (err),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   typedef struct {
      logic [31:0] spo;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_spo;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Called just after a rising edge. k<0: slave never answers; otherwise
   // mem_ready is raised k cycles after mem_valid becomes visible.
   task automatic run_access(input string tag, input bit wr, input bit rdr,
                             input logic [31:0] addr, input logic [31:0] wdat,
                             input int k, input logic [31:0] rdat, input int hold);
      exp_t e;
      int   cyc;
      bit   done;
      bit   timed_out;
      timed_out = (k < 0) || (k > TO - 1);
      e.err = timed_out;
      e.lat = timed_out ? TO + 1 : k + 2;
      if (!wr) model_spo = timed_out ? 32'hDEADBEEF : swap(rdat);
      e.spo = model_spo;
      exp_q.push_back(e);

      a = addr; d = wdat; we = wr; rd = rdr;
      cyc = 0; done = 1'b0;
      while (!done && cyc < TO + 8) begin
         @(posedge clk); #1;
         cyc++;
         mem_ready = (k >= 0) && (cyc == k + 1);
         mem_rdata = mem_ready ? rdat : $urandom;
         if (cyc == 1) begin
            check_eq({tag, "/valid"}, 32'(mem_valid), 32'd1);
            check_eq({tag, "/addr"}, mem_addr, {addr[31:2], 2'b00});
            check_eq({tag, "/wstrb"}, 32'(mem_wstrb), wr ? 32'hF : 32'h0);
            if (wr) check_eq({tag, "/wdata"}, mem_wdata, swap(wdat));
         end
         if (timed_out && cyc == TO) check_eq({tag, "/valid_last"}, 32'(mem_valid), 32'd1);
         if (ready) done = 1'b1;
      end
      mem_ready = 1'b0;

      if (!done) begin
         check_eq({tag, "/no_ready"}, 32'd0, 32'd1);
         exp_q.delete();
      end else if (exp_q.size() == 0) begin
         check_eq({tag, "/unexpected_ready"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq({tag, "/latency"}, 32'(cyc), 32'(e.lat));
         check_eq({tag, "/err"}, 32'(err), 32'(e.err));
         check_eq({tag, "/spo"}, spo, e.spo);
         check_eq({tag, "/valid_drop"}, 32'(mem_valid), 32'd0);
      end

      repeat (hold) begin
         @(posedge clk); #1;
         check_eq({tag, "/hold_ready"}, 32'(ready), 32'd0);
         check_eq({tag, "/hold_valid"}, 32'(mem_valid), 32'd0);
      end
      we = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "/ready_pulse"}, 32'(ready), 32'd0);
      check_eq({tag, "/err_pulse"}, 32'(err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      resetn = 1'b0; a = '0; d = '0; we = 1'b0; rd = 1'b0;
      mem_ready = 1'b0; mem_rdata = '0; model_spo = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst/spo", spo, 32'h0);
      check_eq("rst/ready", 32'(ready), 32'd0);
      check_eq("rst/err", 32'(err), 32'd0);
      check_eq("rst/valid", 32'(mem_valid), 32'd0);
      check_eq("rst/addr", mem_addr, 32'h0);
      check_eq("rst/wdata", mem_wdata, 32'h0);
      check_eq("rst/wstrb", 32'(mem_wstrb), 32'h0);
      check_eq("rst/instr", 32'(mem_instr), 32'd0);
      resetn = 1'b1;

      run_access("rd_k3", 1'b0, 1'b1, 32'h2000_0006, 32'h0, 3, 32'h1122_3344, 0);
      check_eq("rd_k3/spo_const", spo, 32'h4433_2211);

      run_access("wr_k0", 1'b1, 1'b0, 32'h2000_0010, 32'hA1B2_C3D4, 0, 32'h5555_5555, 0);
      check_eq("wr_k0/spo_kept", spo, 32'h4433_2211);

      // Held request: one burst, one pulse, then back-to-back read.
      run_access("rd_hold", 1'b0, 1'b1, 32'h2000_0020, 32'h0, 1, 32'hCAFE_0001, 6);
      run_access("rd_next", 1'b0, 1'b1, 32'h2000_0024, 32'h0, 2, 32'h0BAD_F00D, 0);

      run_access("rd_to", 1'b0, 1'b1, 32'h4000_0000, 32'h0, -1, 32'h0, 0);
      check_eq("rd_to/spo_const", spo, 32'hDEAD_BEEF);
      run_access("wr_to", 1'b1, 1'b0, 32'h4000_0004, 32'h1234_5678, -1, 32'h0, 0);

      run_access("rdwr", 1'b1, 1'b1, 32'h2000_0030, 32'h0102_0304, 2, 32'h7777_7777, 0);
      check_eq("rdwr/spo_kept", spo, 32'hDEAD_BEEF);

      run_access("rd_edge", 1'b0, 1'b1, 32'h2000_0040, 32'h0, TO - 1, 32'h8899_AABB, 0);
      run_access("rd_late", 1'b0, 1'b1, 32'h2000_0044, 32'h0, TO, 32'h1357_9BDF, 0);
      run_access("rd_ok2", 1'b0, 1'b1, 32'h2000_0048, 32'h0, 4, 32'hF0E1_D2C3, 0);

      // Asynchronous reset in the middle of a busy access.
      a = 32'h3000_0010; rd = 1'b1; we = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("arst/busy_valid", 32'(mem_valid), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check_eq("arst/valid", 32'(mem_valid), 32'd0);
      check_eq("arst/ready", 32'(ready), 32'd0);
      check_eq("arst/spo", spo, 32'h0);
      check_eq("arst/err", 32'(err), 32'd0);
      rd = 1'b0;
      model_spo = '0;
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         check_eq("arst/no_ready", 32'(ready), 32'd0);
         check_eq("arst/no_valid", 32'(mem_valid), 32'd0);
      end
      run_access("rd_post", 1'b0, 1'b1, 32'h2000_0050, 32'h0, 0, 32'h2468_ACE0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
